interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt sources (1..8).
REQ-002 Parameter CAUSE_BASE, default 8: icause value reported for source 0.
REQ-003 Parameter DEF_HANDLER, default 32'h8000f000: reset value of every handler register.
REQ-004 clk  in  1  single clock; every register updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 irq_src  in  NSRC  raw interrupt requests; bit i is source i.
REQ-007 irq  out  1  interrupt request to the CPU (registered).
REQ-008 icause  out  4  cause code of the asserted interrupt (registered).
REQ-009 isr_addr  out  32  handler address of the asserted source (registered).
REQ-010 iack  in  1  CPU acknowledge, one-cycle pulse.
REQ-011 a  in  32  bus address.
REQ-012 d  in  32  bus write data.
REQ-013 we  in  1  bus write enable.
REQ-014 spo  out  32  bus read data, combinational from a.

Function
REQ-015 Register decode SHALL apply only when a[31:16]==16'h8000; all other reads return 0 and all other writes are ignored.
REQ-016 For source i, offset 0x1000*(i+1)+0 is the handler (32b RW), +4 the mask (bit0 RW, 1=masked) and +8 the mode (bit0 RW, 0=level, 1=rising edge).
REQ-017 Offset 0x0F00 SHALL read the pending vector zero-extended; a write clears every pending bit whose d bit is 1 (W1C).
REQ-018 Offset 0x0F04 SHALL read 0; a write sets every pending bit whose d bit is 1 (software trigger).
REQ-019 Offset 0xF000 SHALL read the constant 32'h03e00008 (return instruction); any other offset SHALL read 0.
REQ-020 Level mode: pending[i] is set on every edge where irq_src[i]=1. Edge mode: pending[i] is set only where irq_src[i]=1 and its one-cycle delayed copy is 0.
REQ-021 Pending bits latch regardless of mask; masking gates only selection.
REQ-022 Selection: the lowest-index bit with pending=1 and mask=0 wins (fixed priority).
REQ-023 FSM IDLE: when a selection exists, latch its index, drive irq<=1, icause<=CAUSE_BASE+idx and isr_addr<=handler[idx], then enter ASSERT.
REQ-024 FSM ASSERT: hold irq, icause and isr_addr stable; a higher-priority arrival SHALL NOT preempt; mask or handler writes to the latched source SHALL NOT drop or alter the request.
REQ-025 ASSERT with iack=1: clear pending[idx], drive irq<=0 and icause<=0, then enter GAP.
REQ-026 FSM GAP: lasts exactly one cycle with irq=0, then returns to IDLE.
REQ-027 Latency: a source sampled high at edge t (unmasked, FSM in IDLE) SHALL produce irq=1 after edge t+1.
REQ-028 Simultaneous set and clear of the same pending bit (source set, iack or W1C in the same cycle): the set wins and the bit stays 1.
REQ-029 Level-mode sources still high after iack SHALL re-pend and re-request after GAP.
REQ-030 iack seen in IDLE or GAP SHALL be ignored.

Reset
REQ-031 rst SHALL set: handlers=DEF_HANDLER, masks=1, modes=0, pending=0, delayed source copies=0, irq=0, icause=0, isr_addr=DEF_HANDLER, FSM=IDLE.
REQ-032 rst asserted mid-ASSERT SHALL drop irq on the next edge and discard the latched request with no acknowledge needed.

Structure
REQ-033 Package interrupt_pkg SHALL hold the register offsets, the return-instruction constant, DEF_HANDLER and the FSM state encodings (IDLE, ASSERT, GAP).
REQ-034 Sub-module ic_prio_enc SHALL implement combinational lowest-index-first selection (input NSRC-bit vector; outputs valid and index).

Verification
REQ-035 Reset, then read 0x80001000 and 0x80001004 -> 32'h8000f000 and 1; irq_src=4'b0001 -> irq stays 0.
REQ-036 Write 0 to 0x80001004, pulse irq_src[0] at edge t -> irq=1 and icause=8 after t+1; iack -> irq=0, one GAP cycle, no re-request.
REQ-037 Unmask sources 0 and 2, assert both in the same cycle -> icause=8 first; after iack and GAP -> icause=10.
REQ-038 Source 1 in level mode, handler 0x00400100, held high across iack -> after GAP, irq=1 again with isr_addr=0x00400100.
REQ-039 Source 3 in edge mode, held high for 10 cycles -> exactly one request; write 4'b1000 to 0x80000F04 -> one more request with icause=11.
REQ-040 Assert rst during ASSERT -> irq=0 and icause=0 next edge; pending reads 0 at 0x80000F00.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared constants for the interrupt controller: register map, reset values
// and FSM state encoding.
package interrupt_pkg;

  localparam logic [15:0] REG_PAGE    = 16'h8000;
  localparam logic [15:0] OFF_PEND    = 16'h0F00;
  localparam logic [15:0] OFF_SWTRIG  = 16'h0F04;
  localparam logic [15:0] OFF_RET     = 16'hF000;
  localparam logic [15:0] OFF_HANDLER = 16'h0000;
  localparam logic [15:0] OFF_MASK    = 16'h0004;
  localparam logic [15:0] OFF_MODE    = 16'h0008;

  localparam logic [31:0] RET_INSN    = 32'h03e0_0008;
  localparam logic [31:0] DEF_HANDLER = 32'h8000_f000;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GAP
  } ic_state_e;

  // Per-source register block base: source i lives at 0x1000*(i+1).
  function automatic logic [15:0] src_base(input int unsigned i);
    return 16'((i + 1) << 12);
  endfunction

endpackage

// File: rtl/ic_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of the request vector.
module ic_prio_enc #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NSRC-1:0] i_req,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (i_req[i] && !o_valid) begin
        o_valid = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: per-source handler/mask/mode registers,
// pending latch, fixed-priority selection and a request/acknowledge FSM.
module interrupt_controller #(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned CAUSE_BASE  = 8,
  parameter logic [31:0] DEF_HANDLER = interrupt_pkg::DEF_HANDLER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq,
  output logic [3:0]      icause,
  output logic [31:0]     isr_addr,
  input  logic            iack,
  input  logic [31:0]     a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo
);

  import interrupt_pkg::*;

  localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [31:0]     r_handler [NSRC];
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_mode;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_src_d;
  logic [IW-1:0]   r_idx;
  ic_state_e       r_state;
  ic_state_e       w_state_nx;

  logic            w_hit;
  logic            w_wr;
  logic [15:0]     w_off;
  logic            w_ack;
  logic            w_sel_valid;
  logic [IW-1:0]   w_sel_idx;
  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_clr;

  assign w_hit = (a[31:16] == REG_PAGE);
  assign w_off = a[15:0];
  assign w_wr  = we && w_hit;
  assign w_ack = (r_state == ASSERT) && iack;

  // Edge-mode sources only set on a 0->1 transition of the raw input.
  assign w_set = (irq_src & ~(r_mode & r_src_d))
               | ((w_wr && w_off == OFF_SWTRIG) ? d[NSRC-1:0] : '0);
  assign w_clr = ((w_wr && w_off == OFF_PEND) ? d[NSRC-1:0] : '0)
               | (w_ack ? (NSRC'(1) << r_idx) : '0);

  ic_prio_enc #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_prio (
    .i_req   (r_pend & ~r_mask),
    .o_valid (w_sel_valid),
    .o_idx   (w_sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask  <= '1;
      r_mode  <= '0;
      r_pend  <= '0;
      r_src_d <= '0;
      for (int unsigned i = 0; i < NSRC; i++) r_handler[i] <= DEF_HANDLER;
    end else begin
      r_src_d <= irq_src;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (w_wr && w_off == src_base(i) + OFF_HANDLER) r_handler[i] <= d;
        if (w_wr && w_off == src_base(i) + OFF_MASK)    r_mask[i]    <= d[0];
        if (w_wr && w_off == src_base(i) + OFF_MODE)    r_mode[i]    <= d[0];
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_sel_valid) w_state_nx = ASSERT;
      ASSERT:  if (iack)        w_state_nx = GAP;
      GAP:                      w_state_nx = IDLE;
      default:                  w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      irq      <= 1'b0;
      icause   <= '0;
      isr_addr <= DEF_HANDLER;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && w_sel_valid) begin
        r_idx    <= w_sel_idx;
        irq      <= 1'b1;
        icause   <= 4'(CAUSE_BASE) + 4'(w_sel_idx);
        isr_addr <= r_handler[w_sel_idx];
      end else if (w_ack) begin
        irq    <= 1'b0;
        icause <= '0;
      end
    end
  end

  always_comb begin
    spo = '0;
    if (w_hit) begin
      if (w_off == OFF_PEND) spo = 32'(r_pend);
      if (w_off == OFF_RET)  spo = RET_INSN;
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (w_off == src_base(i) + OFF_HANDLER) spo = r_handler[i];
        if (w_off == src_base(i) + OFF_MASK)    spo = {31'b0, r_mask[i]};
        if (w_off == src_base(i) + OFF_MODE)    spo = {31'b0, r_mode[i]};
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_src;
  logic        irq;
  logic [3:0]  icause;
  logic [31:0] isr_addr;
  logic        iack;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller #(
    .NSRC        (4),
    .CAUSE_BASE  (8),
    .DEF_HANDLER (32'h8000_f000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .irq      (irq),
    .icause   (icause),
    .isr_addr (isr_addr),
    .iack     (iack),
    .a        (a),
    .d        (d),
    .we       (we),
    .spo      (spo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    a  = addr;
    d  = data;
    we = 1'b1;
    tick();
    we = 1'b0;
    a  = '0;
    d  = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    @(negedge clk);
    check(tag, spo, exp);
    a = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   nreq;
    logic prev;
    logic [3:0] cause_seen;

    rst = 1'b1; iack = 1'b0; we = 1'b0; a = '0; d = '0; irq_src = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and register map
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_icause", 32'(icause), 32'd0);
    check("rst_isr", isr_addr, 32'h8000_f000);
    rd_check("rd_h0", 32'h8000_1000, 32'h8000_f000);
    rd_check("rd_m0", 32'h8000_1004, 32'd1);
    rd_check("rd_mode0", 32'h8000_1008, 32'd0);
    rd_check("rd_h2", 32'h8000_3000, 32'h8000_f000);
    rd_check("rd_ret", 32'h8000_F000, 32'h03e0_0008);
    rd_check("rd_swtrig", 32'h8000_0F04, 32'd0);
    rd_check("rd_offpage", 32'h9000_1000, 32'd0);
    rd_check("rd_unmapped", 32'h8000_0F08, 32'd0);

    // Masked source latches pending but never requests
    irq_src = 4'b0001;
    repeat (4) tick();
    check("masked_irq", 32'(irq), 32'd0);
    irq_src = '0;
    tick();
    rd_check("pend_masked", 32'h8000_0F00, 32'd1);
    wr(32'h8000_0F00, 32'd1);
    rd_check("pend_w1c", 32'h8000_0F00, 32'd0);
    wr(32'h9000_1004, 32'd0);
    rd_check("offpage_wr_ignored", 32'h8000_1004, 32'd1);

    // Single pulse on source 0: latency, ack, gap, no re-request
    wr(32'h8000_1004, 32'd0);
    rd_check("unmask0", 32'h8000_1004, 32'd0);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    check("lat_t_irq", 32'(irq), 32'd0);
    tick();
    check("lat_t1_irq", 32'(irq), 32'd1);
    check("lat_t1_cause", 32'(icause), 32'd8);
    check("lat_t1_isr", isr_addr, 32'h8000_f000);
    tick(); tick();
    check("hold_irq", 32'(irq), 32'd1);
    iack = 1'b1; tick(); iack = 1'b0;
    check("ack_irq", 32'(irq), 32'd0);
    check("ack_cause", 32'(icause), 32'd0);
    tick();
    check("gap_irq", 32'(irq), 32'd0);
    tick(); tick();
    check("norereq_irq", 32'(irq), 32'd0);
    rd_check("pend_after_ack", 32'h8000_0F00, 32'd0);

    // iack in IDLE is ignored; software trigger on a masked source
    wr(32'h8000_0F04, 32'd2);
    iack = 1'b1; tick(); iack = 1'b0;
    rd_check("idle_iack_pend", 32'h8000_0F00, 32'd2);
    check("idle_iack_irq", 32'(irq), 32'd0);
    wr(32'h8000_0F00, 32'd2);
    rd_check("swtrig_cleared", 32'h8000_0F00, 32'd0);

    // Sources 0 and 2 together: priority order, no preemption
    wr(32'h8000_3004, 32'd0);
    irq_src = 4'b0101;
    tick();
    irq_src = '0;
    tick();
    check("prio_first_irq", 32'(irq), 32'd1);
    check("prio_first_cause", 32'(icause), 32'd8);
    iack = 1'b1; tick(); iack = 1'b0;
    check("prio_ack_irq", 32'(irq), 32'd0);
    tick();
    check("prio_gap_irq", 32'(irq), 32'd0);
    tick();
    check("prio_second_irq", 32'(irq), 32'd1);
    check("prio_second_cause", 32'(icause), 32'd10);
    wr(32'h8000_3004, 32'd1);
    wr(32'h8000_3000, 32'h1234_0000);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick();
    check("nopreempt_irq", 32'(irq), 32'd1);
    check("nopreempt_cause", 32'(icause), 32'd10);
    check("nopreempt_isr", isr_addr, 32'h8000_f000);
    iack = 1'b1; tick(); iack = 1'b0;
    tick(); tick();
    check("late0_irq", 32'(irq), 32'd1);
    check("late0_cause", 32'(icause), 32'd8);
    iack = 1'b1; tick(); iack = 1'b0;
    check("late0_ack", 32'(irq), 32'd0);
    tick();

    // Level source 1 held across iack re-requests
    wr(32'h8000_2000, 32'h0040_0100);
    wr(32'h8000_2004, 32'd0);
    irq_src = 4'b0010;
    tick(); tick();
    check("lvl_irq", 32'(irq), 32'd1);
    check("lvl_cause", 32'(icause), 32'd9);
    check("lvl_isr", isr_addr, 32'h0040_0100);
    iack = 1'b1; tick(); iack = 1'b0;
    check("lvl_ack_irq", 32'(irq), 32'd0);
    rd_check("lvl_set_wins", 32'h8000_0F00, 32'd2);
    tick();
    check("lvl_gap_irq", 32'(irq), 32'd0);
    tick();
    check("lvl_rereq_irq", 32'(irq), 32'd1);
    check("lvl_rereq_isr", isr_addr, 32'h0040_0100);
    check("lvl_rereq_cause", 32'(icause), 32'd9);
    irq_src = '0;
    iack = 1'b1; tick(); iack = 1'b0;
    check("lvl_final_ack", 32'(irq), 32'd0);
    tick(); tick();
    check("lvl_quiet", 32'(irq), 32'd0);
    rd_check("lvl_pend_clear", 32'h8000_0F00, 32'd0);

    // W1C racing a live level source: set wins
    wr(32'h8000_2004, 32'd1);
    irq_src = 4'b0010;
    tick();
    wr(32'h8000_0F00, 32'd2);
    rd_check("w1c_set_wins", 32'h8000_0F00, 32'd2);
    irq_src = '0;
    wr(32'h8000_0F00, 32'd2);
    rd_check("w1c_after_drop", 32'h8000_0F00, 32'd0);

    // Edge-mode source 3 held for 10 cycles: one request only
    wr(32'h8000_4008, 32'd1);
    wr(32'h8000_4004, 32'd0);
    rd_check("mode3", 32'h8000_4008, 32'd1);
    nreq = 0;
    prev = 1'b0;
    cause_seen = '0;
    irq_src = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (irq && !prev) begin
        nreq++;
        cause_seen = icause;
      end
      prev = irq;
      iack = irq;
    end
    irq_src = '0;
    iack = 1'b0;
    tick(); tick();
    check("edge_nreq", 32'(nreq), 32'd1);
    check("edge_cause", 32'(cause_seen), 32'd11);
    check("edge_quiet", 32'(irq), 32'd0);
    wr(32'h8000_0F04, 32'd8);
    check("swtrig_lat_irq", 32'(irq), 32'd0);
    tick();
    check("swtrig_irq", 32'(irq), 32'd1);
    check("swtrig_cause", 32'(icause), 32'd11);

    // Reset during ASSERT discards the request
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_irq", 32'(irq), 32'd0);
    check("rst_mid_cause", 32'(icause), 32'd0);
    check("rst_mid_isr", isr_addr, 32'h8000_f000);
    rd_check("rst_mid_pend", 32'h8000_0F00, 32'd0);
    rd_check("rst_mid_mode3", 32'h8000_4008, 32'd0);
    rd_check("rst_mid_h1", 32'h8000_2000, 32'h8000_f000);
    rd_check("rst_mid_m3", 32'h8000_4004, 32'd1);
    tick(); tick();
    check("rst_mid_quiet", 32'(irq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
